// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: operand prep feeds stage 1, result and flags are registered in stage 2.
// Valid/ready on both sides; capacity of two operations, delivered in order.
module alu_pipe #(
    parameter int unsigned OPERAND_WIDTH  = 16,
    parameter int unsigned NUM_OPERATIONS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPERAND_WIDTH-1:0]  InA,
    input  logic [OPERAND_WIDTH-1:0]  InB,
    input  logic                      Cin,
    input  logic [NUM_OPERATIONS-1:0] Oper,
    input  logic                      invA,
    input  logic                      invB,
    input  logic                      sign,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPERAND_WIDTH-1:0]  Out,
    output logic                      Ofl,
    output logic                      Cout,
    output logic                      Zero,
    output logic                      Neg,
    output logic                      ofl_sticky,
    input  logic                      clr_sticky
);

    localparam int unsigned W           = OPERAND_WIDTH;
    localparam int unsigned SUM_W       = OPERAND_WIDTH + 1;
    localparam int unsigned SHAMT_WIDTH = $clog2(OPERAND_WIDTH);

    localparam logic [NUM_OPERATIONS-1:0] OP_ROL = NUM_OPERATIONS'(0);
    localparam logic [NUM_OPERATIONS-1:0] OP_SHL = NUM_OPERATIONS'(1);
    localparam logic [NUM_OPERATIONS-1:0] OP_ROR = NUM_OPERATIONS'(2);
    localparam logic [NUM_OPERATIONS-1:0] OP_SHR = NUM_OPERATIONS'(3);
    localparam logic [NUM_OPERATIONS-1:0] OP_ADD = NUM_OPERATIONS'(4);
    localparam logic [NUM_OPERATIONS-1:0] OP_AND = NUM_OPERATIONS'(5);
    localparam logic [NUM_OPERATIONS-1:0] OP_OR  = NUM_OPERATIONS'(6);
    localparam logic [NUM_OPERATIONS-1:0] OP_XOR = NUM_OPERATIONS'(7);

    // Stage 1 registers
    logic                      r_s1_valid;
    logic [W-1:0]              r_s1_a;
    logic [W-1:0]              r_s1_b;
    logic                      r_s1_cin;
    logic [NUM_OPERATIONS-1:0] r_s1_oper;
    logic                      r_s1_sign;

    // Stage 2 registers (drive the outputs)
    logic                      r_s2_valid;
    logic [W-1:0]              r_out;
    logic                      r_ofl;
    logic                      r_cout;
    logic                      r_zero;
    logic                      r_neg;
    logic                      r_sticky;

    logic                      w_s2_adv;
    logic                      w_s1_adv;
    logic                      w_in_xfer;
    logic                      w_out_xfer;
    logic [SHAMT_WIDTH-1:0]    w_sh;
    logic [2*W-1:0]            w_rol_full;
    logic [2*W-1:0]            w_ror_full;
    logic [W:0]                w_sum;
    logic [W-1:0]              w_res;
    logic                      w_ofl;
    logic                      w_cout;

    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_adv;
    assign in_ready   = !r_s1_valid || w_s2_adv;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_s2_valid && out_ready;

    // Rotates taken from a doubled operand so sh = 0 falls out naturally
    assign w_sh       = r_s1_b[SHAMT_WIDTH-1:0];
    assign w_rol_full = {r_s1_a, r_s1_a} << w_sh;
    assign w_ror_full = {r_s1_a, r_s1_a} >> w_sh;
    assign w_sum      = SUM_W'(r_s1_a) + SUM_W'(r_s1_b) + SUM_W'(r_s1_cin);

    // Stage 2 result and flag computation
    always_comb begin
        w_res  = '0;
        w_ofl  = 1'b0;
        w_cout = 1'b0;
        case (r_s1_oper)
            OP_ROL: w_res = w_rol_full[2*W-1:W];
            OP_SHL: w_res = r_s1_a << w_sh;
            OP_ROR: w_res = w_ror_full[W-1:0];
            OP_SHR: w_res = r_s1_a >> w_sh;
            OP_ADD: begin
                w_res  = w_sum[W-1:0];
                w_cout = w_sum[W];
                w_ofl  = r_s1_sign ? (w_sum[W-1] ^ r_s1_a[W-1] ^ r_s1_b[W-1] ^ w_sum[W])
                                   : w_sum[W];
            end
            OP_AND: w_res = r_s1_a & r_s1_b;
            OP_OR:  w_res = r_s1_a | r_s1_b;
            OP_XOR: w_res = r_s1_a ^ r_s1_b;
            default: w_res = '0;
        endcase
    end

    // Stage 1 capture with operand inversion applied up front
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_oper  <= '0;
            r_s1_sign  <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= invA ? ~InA : InA;
            r_s1_b     <= invB ? ~InB : InB;
            r_s1_cin   <= Cin;
            r_s1_oper  <= Oper;
            r_s1_sign  <= sign;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2 capture; data holds whenever nothing new arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out      <= '0;
            r_ofl      <= 1'b0;
            r_cout     <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out  <= w_res;
                r_ofl  <= w_ofl;
                r_cout <= w_cout;
                r_zero <= (w_res == '0);
                r_neg  <= w_res[W-1];
            end
        end
    end

    // Sticky overflow: a delivered overflow beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_out_xfer && r_ofl) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign out_valid  = r_s2_valid;
    assign Out        = r_out;
    assign Ofl        = r_ofl;
    assign Cout       = r_cout;
    assign Zero       = r_zero;
    assign Neg        = r_neg;
    assign ofl_sticky = r_sticky;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases plus random traffic scored against a queue-based reference.
module tb_alu_pipe;

    localparam int unsigned TW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [TW-1:0] InA = '0, InB = '0;
    logic          Cin = 1'b0;
    logic [2:0]    Oper = '0;
    logic          invA = 1'b0, invB = 1'b0, sign = 1'b0;
    logic          out_valid, out_ready = 1'b0;
    logic [TW-1:0] Out;
    logic          Ofl, Cout, Zero, Neg, ofl_sticky;
    logic          clr_sticky = 1'b0;

    logic          in_valid32 = 1'b0, in_ready32;
    logic [31:0]   a32 = '0, b32 = '0;
    logic [2:0]    oper32 = '0;
    logic          out_valid32;
    logic [31:0]   out32;
    logic          ofl32, cout32, zero32, neg32, sticky32;

    always #5 clk = ~clk;

    alu_pipe #(.OPERAND_WIDTH(TW), .NUM_OPERATIONS(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .InA(InA), .InB(InB), .Cin(Cin), .Oper(Oper), .invA(invA), .invB(invB),
        .sign(sign), .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
        .Ofl(Ofl), .Cout(Cout), .Zero(Zero), .Neg(Neg),
        .ofl_sticky(ofl_sticky), .clr_sticky(clr_sticky)
    );

    alu_pipe #(.OPERAND_WIDTH(32), .NUM_OPERATIONS(3)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .InA(a32), .InB(b32), .Cin(1'b0), .Oper(oper32), .invA(1'b0), .invB(1'b0),
        .sign(1'b0), .out_valid(out_valid32), .out_ready(1'b1), .Out(out32),
        .Ofl(ofl32), .Cout(cout32), .Zero(zero32), .Neg(neg32),
        .ofl_sticky(sticky32), .clr_sticky(1'b0)
    );

    typedef struct {
        logic [TW-1:0] out;
        logic          ofl, cout, zero, neg;
        int            cyc;
    } exp_t;

    exp_t        q[$];
    int          edge_n   = 0;
    logic        m_sticky = 1'b0;
    logic [19:0] last_res = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        dmy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] pack(input exp_t e);
        return {e.out, e.ofl, e.cout, e.zero, e.neg};
    endfunction

    // Reference: plain integer arithmetic on the prepared operands
    function automatic exp_t ref_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c,
                                    input logic [2:0] op, input logic ia, input logic ib,
                                    input logic sg);
        logic [TW-1:0]   av, bv;
        longint unsigned ua, ub, r, mask;
        longint          sa, sb, ss;
        int              sh;
        exp_t            e;
        av = ia ? ~a : a;
        bv = ib ? ~b : b;
        ua = av;
        ub = bv;
        mask = (64'd1 << TW) - 1;
        sh = int'(ub % TW);
        e.ofl = 1'b0;
        e.cout = 1'b0;
        e.cyc = 0;
        case (op)
            3'd0: r = (sh == 0) ? ua : (((ua << sh) | (ua >> (TW - sh))) & mask);
            3'd1: r = (ua << sh) & mask;
            3'd2: r = (sh == 0) ? ua : (((ua >> sh) | (ua << (TW - sh))) & mask);
            3'd3: r = ua >> sh;
            3'd4: begin
                r = ua + ub + longint'(c);
                e.cout = (r > mask);
                if (sg) begin
                    sa = (ua >= 64'd32768) ? longint'(ua) - 65536 : longint'(ua);
                    sb = (ub >= 64'd32768) ? longint'(ub) - 65536 : longint'(ub);
                    ss = sa + sb + longint'(c);
                    e.ofl = (ss > 32767) || (ss < -32768);
                end else begin
                    e.ofl = e.cout;
                end
                r = r & mask;
            end
            3'd5: r = ua & ub;
            3'd6: r = ua | ub;
            default: r = ua ^ ub;
        endcase
        e.out  = TW'(r);
        e.zero = (r == 0);
        e.neg  = e.out[TW-1];
        return e;
    endfunction

    // One clock of traffic: predict handshake, advance the model, then score the outputs
    task automatic drive(input logic iv, input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic c, input logic [2:0] op, input logic ia, input logic ib,
                         input logic sg, input logic ordy, input logic clr, output logic acc);
        exp_t e;
        logic exp_ov, exp_ir, ox;
        in_valid = iv; InA = a; InB = b; Cin = c; Oper = op;
        invA = ia; invB = ib; sign = sg; out_ready = ordy; clr_sticky = clr;
        #1;
        exp_ov = (q.size() > 0) && (q[0].cyc < edge_n);
        exp_ir = (q.size() < 2) || ordy;
        check("in_ready", 64'(in_ready), 64'(exp_ir));
        ox  = exp_ov && ordy;
        acc = iv && exp_ir;
        if (ox && q[0].ofl) m_sticky = 1'b1;
        else if (clr)       m_sticky = 1'b0;
        e = ref_op(a, b, c, op, ia, ib, sg);
        @(posedge clk);
        edge_n++;
        if (ox) void'(q.pop_front());
        if (acc) begin
            e.cyc = edge_n;
            q.push_back(e);
        end
        #1;
        exp_ov = (q.size() > 0) && (q[0].cyc < edge_n);
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) last_res = pack(q[0]);
        check("result", 64'({Out, Ofl, Cout, Zero, Neg}), 64'(last_res));
        check("sticky", 64'(ofl_sticky), 64'(m_sticky));
    endtask

    task automatic idle(input logic ordy, input logic clr);
        drive(1'b0, '0, '0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ordy, clr, dmy);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        @(posedge clk);
        edge_n++;
        #1;
        rst = 1'b0;
        q.delete();
        m_sticky = 1'b0;
        last_res = '0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'({Out, Ofl, Cout, Zero, Neg}), 64'd0);
        check("rst_sticky", 64'(ofl_sticky), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n, cyc_n;
        logic a_ok;
        do_reset();

        // Signed overflow add, latency and sticky set
        drive(1, 16'h7FFF, 16'h0001, 0, 3'd4, 0, 0, 1, 1, 0, dmy);
        check("lat_early", 64'(out_valid), 64'd0);
        idle(1, 0);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_out", 64'(Out), 64'h8000);
        check("add_flags", 64'({Ofl, Cout, Neg, Zero}), 64'b1010);
        idle(1, 0);
        check("add_sticky", 64'(ofl_sticky), 64'd1);

        // Unsigned wrap and subtraction through invB/Cin
        drive(1, 16'hFFFF, 16'h0001, 0, 3'd4, 0, 0, 0, 1, 0, dmy);
        idle(1, 0);
        check("wrap_out", 64'(Out), 64'h0000);
        check("wrap_flags", 64'({Zero, Cout, Ofl}), 64'b111);
        drive(1, 16'd5, 16'd3, 1, 3'd4, 0, 1, 1, 1, 0, dmy);
        idle(1, 0);
        check("sub_out", 64'(Out), 64'h0002);
        check("sub_flags", 64'({Cout, Ofl}), 64'b10);

        // Back-to-back shifts and rotates
        drive(1, 16'h8001, 16'h0004, 0, 3'd0, 0, 0, 0, 1, 0, dmy);
        drive(1, 16'h8001, 16'h0004, 0, 3'd2, 0, 0, 0, 1, 0, dmy);
        check("rol", 64'(Out), 64'h0018);
        drive(1, 16'h8001, 16'h0004, 0, 3'd3, 0, 0, 0, 1, 0, dmy);
        check("ror", 64'(Out), 64'h1800);
        drive(1, 16'h8001, 16'h0010, 0, 3'd1, 0, 0, 0, 1, 0, dmy);
        check("shr", 64'(Out), 64'h0800);
        idle(1, 0);
        check("shl_sh0", 64'(Out), 64'h8001);
        idle(1, 0);

        // Backpressure: two accepted, third stalls until out_ready rises
        drive(1, 16'hF0F0, 16'h0FF0, 0, 3'd5, 0, 0, 0, 0, 0, dmy);
        drive(1, 16'hF0F0, 16'h0FF0, 0, 3'd6, 0, 0, 0, 0, 0, dmy);
        Oper = 3'd7;
        #1;
        check("bp_full", 64'(in_ready), 64'd0);
        drive(1, 16'hF0F0, 16'h0FF0, 0, 3'd7, 0, 0, 0, 0, 0, a_ok);
        check("bp_hold", 64'(Out), 64'h00F0);
        drive(1, 16'hF0F0, 16'h0FF0, 0, 3'd7, 0, 0, 0, 1, 0, a_ok);
        check("bp_or", 64'(Out), 64'hFFF0);
        idle(1, 0);
        check("bp_xor", 64'(Out), 64'hFF00);
        idle(1, 0);
        check("bp_drained", 64'({out_valid, in_ready}), 64'b01);

        // Sticky: set beats clear, then clear alone
        drive(1, 16'h7FFF, 16'h0001, 0, 3'd4, 0, 0, 1, 1, 0, dmy);
        idle(1, 0);
        idle(1, 1);
        check("sticky_set_wins", 64'(ofl_sticky), 64'd1);
        idle(1, 1);
        check("sticky_clear", 64'(ofl_sticky), 64'd0);

        // Reset with two operations in flight
        drive(1, 16'h7FFF, 16'h0001, 0, 3'd4, 0, 0, 1, 0, 0, dmy);
        drive(1, 16'h1234, 16'h00FF, 0, 3'd6, 0, 0, 0, 0, 0, dmy);
        do_reset();
        idle(1, 0);
        idle(1, 0);

        // 32-bit instance rotate right by 0x21 & 31 = 1
        a32 = 32'h80000001; b32 = 32'h21; oper32 = 3'd2; in_valid32 = 1'b1;
        @(posedge clk); edge_n++; #1;
        in_valid32 = 1'b0;
        @(posedge clk); edge_n++; #1;
        check("w32_valid", 64'(out_valid32), 64'd1);
        check("w32_ror", 64'(out32), 64'hC0000000);

        // Random traffic with random backpressure
        acc_n = 0;
        cyc_n = 0;
        while (acc_n < 10000 && cyc_n < 60000) begin
            drive($urandom_range(0, 9) < 7, TW'($urandom), TW'($urandom), 1'($urandom),
                  3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, a_ok);
            if (a_ok) acc_n++;
            cyc_n++;
        end
        check("rand_accepted", 64'(acc_n), 64'd10000);
        for (int i = 0; i < 4; i++) idle(1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Pipelined, width-parametrised successor to the single-cycle hierarchical ALU.
- Supports the same eight operations, operand inversion, carry-in and signed/unsigned overflow.
- Adds a two-stage registered datapath with valid/ready handshakes on both sides, flags valid for every operation, and a sticky overflow register.
- Sits between decode/operand-forwarding logic and the writeback/flag logic of the execute stage.

Parameters:
- OPERAND_WIDTH, 16, operand/result width in bits; power of two, >= 4.
- NUM_OPERATIONS, 3, width of Oper; fixed at 3.
- SHAMT_WIDTH (localparam), log2(OPERAND_WIDTH), number of low bits of B used as the shift/rotate amount.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream holds a valid operation
- in_ready  out  1  block can accept an operation this cycle
- InA  in  OPERAND_WIDTH  operand A, before inversion
- InB  in  OPERAND_WIDTH  operand B, before inversion
- Cin  in  1  carry-in (add only)
- Oper  in  NUM_OPERATIONS  operation select
- invA  in  1  invert A before use
- invB  in  1  invert B before use
- sign  in  1  1 = signed overflow rule, 0 = unsigned
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  downstream accepts the result
- Out  out  OPERAND_WIDTH  result
- Ofl  out  1  overflow (add only, else 0)
- Cout  out  1  carry out of the MSB (add only, else 0)
- Zero  out  1  Out == 0, all operations
- Neg  out  1  Out[OPERAND_WIDTH-1], all operations
- ofl_sticky  out  1  set by any delivered result with Ofl=1
- clr_sticky  in  1  clears ofl_sticky

Behaviour:
- Reset (rst high at posedge):
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - Out, Ofl, Cout, Zero, Neg, ofl_sticky = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight operations; no result is ever presented for them.
- Operand prep: A = invA ? ~InA : InA; B = invB ? ~InB : InB. Inversion is performed before stage 1 capture.
- Stage 1 (S1) captures A, B, Cin, Oper, sign.
- Stage 2 (S2) captures Out and all flags. The S2 registers drive the outputs directly.
- Operations (sh = B[SHAMT_WIDTH-1:0], W = OPERAND_WIDTH):
  - 000: rotate left A by sh
  - 001: shift left A by sh, zero fill
  - 010: rotate right A by sh
  - 011: shift right logical A by sh
  - 100: A + B + Cin
  - 101: A & B
  - 110: A | B
  - 111: A ^ B
  - sh = 0 returns A unchanged for all four shift/rotate operations.
- Add flags (W+1-bit sum):
  - Cout = sum[W].
  - sign=1: Ofl = sum[W-1] ^ A[W-1] ^ B[W-1] ^ sum[W].
  - sign=0: Ofl = sum[W].
  - For non-add operations, Ofl = Cout = 0.
- Handshakes and latency:
  - Transfer in: in_valid & in_ready at a posedge.
  - Transfer out: out_valid & out_ready at a posedge.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = !s1_valid | s2_adv. This is a combinational path from out_ready, and it is permitted.
  - Latency: an operation accepted at edge N drives out_valid=1 from edge N+1 onward (visible after two registered stages, i.e. the cycle following the S1→S2 move).
  - Throughput: 1 op/cycle with out_ready held high.
  - Capacity: 2 operations; results are delivered strictly in order.
  - While out_valid=1 and out_ready=0, Out and all flags hold stable.
  - in_valid may deassert without penalty.
  - When out_valid=0, outputs retain their last values.
- Sticky overflow:
  - ofl_sticky sets on an output transfer with Ofl=1.
  - clr_sticky clears it.
  - Same-cycle set and clear: set wins.
- No X propagation from held inputs when in_valid=0. S1 captures only on an input transfer.

Test Plan:
- W=16, in_valid=1 for one cycle, out_ready=1; Oper=100, InA=0x7FFF, InB=0x0001, Cin=0, sign=1 -> out_valid at the prescribed latency; Out=0x8000, Ofl=1, Cout=0, Neg=1, Zero=0; ofl_sticky=1 after the transfer.
- Oper=100, InA=0xFFFF, InB=0x0001, sign=0 -> Out=0x0000, Zero=1, Cout=1, Ofl=1. Subtraction case: InA=5, InB=3, invB=1, Cin=1 -> Out=0x0002, Cout=1, Ofl=0 (sign=1).
- Shifts, W=16:
  - InA=0x8001, InB=0x0004, Oper=000 -> 0x0018.
  - Oper=010 -> 0x1800.
  - Oper=011 -> 0x0800.
  - InB=0x0010 (sh=0), Oper=001 -> 0x8001.
  - Repeat with W=32, InA=0x80000001, InB=0x21, Oper=010 -> 0xC0000000.
- Backpressure: out_ready=0, three back-to-back ops (AND 0xF0F0&0x0FF0, OR, XOR) -> first two accepted, in_ready=0 on the third; Out holds 0x00F0. Raise out_ready -> results delivered in order with no loss or duplication, then in_ready=1.
- Sticky: ofl_sticky=1, clr_sticky=1 in the same cycle as another overflowing add transfers out -> ofl_sticky stays 1. Next cycle clr_sticky=1 alone -> ofl_sticky=0.
- Reset mid-flight: two ops in the pipe with out_ready=0, assert rst for one cycle -> next cycle out_valid=0, Out=0, all flags=0, ofl_sticky=0, in_ready=1; neither op ever appears.
- Random: 10000 random ops with random out_ready, compared against a reference model queue -> zero mismatches.
